// File: rtl/pe_inst_arbiter_pkg.sv
// Shared packet layout and arbiter state encoding for the PE instruction arbiter.
// Packets are {content[13:0], pe_node[3:0]}; the type bit and filter row sit inside content.
package inst_arb_pkg;

    localparam int PKT_W       = 18;
    localparam int PE_NODE_LSB = 0;
    localparam int PE_NODE_MSB = 3;
    localparam int TYPE_BIT    = 4;
    localparam int ROW_LSB     = 5;
    localparam int ROW_MSB     = 7;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [PKT_W-1:0] inst_pkt_t;

endpackage

// File: rtl/pe_inst_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after ptr,
// wrapping modulo N, wins.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && eligible[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pe_inst_arbiter.sv
// Round-robin merge of per-PE instruction FIFOs into one registered injection port.
// A filter sequence locks the grant to its requester until the last filter row leaves.
module pe_inst_arbiter #(
    parameter int N_REQ       = 4,
    parameter int PKT_W       = 18,
    parameter int FILTER_ROWS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PKT_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [PKT_W-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   locked,
    output logic                   err_node
);
    import inst_arb_pkg::*;

    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int ROW_W = ROW_MSB - ROW_LSB + 1;
    localparam int NODE_W = PE_NODE_MSB - PE_NODE_LSB + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FILTER_ROWS - 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);

    arb_state_t        state_reg, state_next;
    logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]     lock_id_reg, lock_id_next;
    logic              out_valid_reg, out_valid_next;
    logic [PKT_W-1:0]  out_data_reg, out_data_next;
    logic              err_node_reg, err_node_next;

    logic [PKT_W-1:0]  req_pkt [N_REQ];
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic              load_en;
    logic              accept;
    logic [PKT_W-1:0]  acc_pkt;
    logic              acc_filter;
    logic              acc_last_row;
    logic [IW-1:0]     gnt_idx_inc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_pkt[gi] = req_data[gi*PKT_W +: PKT_W];
    end

    // While locked, only the lock owner may win, and only when it actually has data.
    always_comb begin
        eligible = '0;
        if (state_reg == IDLE) begin
            eligible = req_valid;
        end else begin
            eligible[lock_id_reg] = req_valid[lock_id_reg];
        end
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_reg),
        .gnt      (gnt),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

    // rst_n gates the handshake so nothing is accepted while reset is held.
    assign load_en   = !out_valid_reg || out_ready;
    assign accept    = gnt_any && load_en && rst_n;
    assign req_ready = gnt & {N_REQ{accept}};

    assign acc_pkt      = req_pkt[gnt_idx];
    assign acc_filter   = acc_pkt[TYPE_BIT];
    assign acc_last_row = (acc_pkt[ROW_MSB:ROW_LSB] == LAST_ROW);
    assign gnt_idx_inc  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        lock_id_next   = lock_id_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        err_node_next  = err_node_reg;
        if (accept) begin
            out_data_next  = acc_pkt;
            out_valid_next = 1'b1;
            if (acc_pkt[PE_NODE_MSB:PE_NODE_LSB] != NODE_W'(gnt_idx)) begin
                err_node_next = 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (acc_filter && !acc_last_row) begin
                        state_next   = LOCKED;
                        lock_id_next = gnt_idx;
                    end else begin
                        rr_ptr_next = gnt_idx_inc;
                    end
                end
                LOCKED: begin
                    if (acc_filter && acc_last_row) begin
                        state_next  = IDLE;
                        rr_ptr_next = gnt_idx_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            lock_id_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            err_node_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            lock_id_reg   <= lock_id_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            err_node_reg  <= err_node_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign locked    = (state_reg == LOCKED);
    assign err_node  = err_node_reg;

endmodule

// File: tb/tb_pe_inst_arbiter.sv
// Directed bench for pe_inst_arbiter: round-robin order, filter locking, backpressure,
// node-mismatch flag and reset in the middle of a lock, checked against a scoreboard.
module tb_pe_inst_arbiter;

    localparam int N     = 4;
    localparam int W     = 18;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic             locked;
    logic             err_node;

    logic [W-1:0]     pkts [N];
    logic [W-1:0]     sb [$];
    logic [W-1:0]     held;
    int               tests;
    int               fails;

    assign req_data = {pkts[3], pkts[2], pkts[1], pkts[0]};

    pe_inst_arbiter #(.N_REQ(4), .PKT_W(18), .FILTER_ROWS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .locked    (locked),
        .err_node  (err_node)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic filt, input int row, input int tag, input int node);
        logic [9:0] t;
        logic [2:0] r;
        logic [3:0] n;
        t = 10'(tag);
        r = 3'(row);
        n = 4'(node);
        return {t, r, filt, n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs settled; returns at the next falling edge.
    task automatic do_cycle(input string tag, input logic [N-1:0] exp_rdy);
        logic [W-1:0] e;
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < N; i++) if (exp_rdy[i]) sb.push_back(pkts[i]);
        @(posedge clk);
        #1;
        if (exp_rdy != '0) begin
            e = sb.pop_front();
            chk({tag, "_ov"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(e));
            $display("[TB] %s grant=%b out_data=%05h", tag, exp_rdy, out_data);
        end else begin
            $display("[TB] %s no grant out_valid=%b", tag, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic ifmap_all(input int base);
        for (int i = 0; i < N; i++) pkts[i] = mk(1'b0, 0, base + i, i);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        ifmap_all(0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err_node), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin over all four ifmap requesters.
        for (int c = 0; c < 5; c++) begin
            ifmap_all(16 + c * 4);
            do_cycle("rr", 4'(1 << (c % 4)));
            chk("rr_locked", 32'(locked), 32'd0);
        end

        // Filter sequence from requester 2 holds the grant for all five rows.
        req_valid = 4'b0100;
        ifmap_all(64);
        pkts[2] = mk(1'b1, 0, 100, 2);
        do_cycle("lock_row0", 4'b0100);
        chk("lock_row0_locked", 32'(locked), 32'd1);
        req_valid = 4'b1111;
        for (int r = 1; r < 5; r++) begin
            if (r == 2) begin
                req_valid = 4'b1011;
                do_cycle("lock_owner_idle", 4'b0000);
                chk("lock_idle_ov", 32'(out_valid), 32'd0);
                chk("lock_idle_locked", 32'(locked), 32'd1);
                req_valid = 4'b1111;
            end
            pkts[2] = mk(1'b1, r, 100 + r, 2);
            do_cycle("lock_row", 4'b0100);
            chk("lock_row_locked", 32'(locked), (r < 4) ? 32'd1 : 32'd0);
        end
        do_cycle("after_lock", 4'b1000);
        held = pkts[3];

        // Backpressure: output held, no grants, then refill without a bubble.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ifmap_all(200 + c * 4);
            do_cycle("bp", 4'b0000);
            chk("bp_hold_data", 32'(out_data), 32'(held));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        do_cycle("bp_refill", 4'b0001);

        // Requester 1 with a mismatched PE_node sets the sticky flag.
        req_valid = 4'b0010;
        pkts[1] = mk(1'b0, 0, 300, 5);
        do_cycle("err_pkt", 4'b0010);
        chk("err_set", 32'(err_node), 32'd1);
        req_valid = 4'b0000;
        do_cycle("err_drain", 4'b0000);
        chk("drain_ov", 32'(out_valid), 32'd0);
        chk("err_sticky", 32'(err_node), 32'd1);

        // Reset in the middle of a lock discards everything.
        req_valid = 4'b0100;
        for (int r = 0; r < 3; r++) begin
            pkts[2] = mk(1'b1, r, 400 + r, 2);
            do_cycle("midlock", 4'b0100);
        end
        chk("midlock_locked", 32'(locked), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_ov", 32'(out_valid), 32'd0);
        chk("mrst_err", 32'(err_node), 32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        ifmap_all(500);
        do_cycle("post_rst", 4'b0001);
        chk("post_rst_locked", 32'(locked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_inst_arbiter.md
# pe_inst_arbiter

Clocked round-robin arbiter that merges the instruction streams of N per-PE instruction FIFOs onto one injection port toward the NoC/ifmap-filter distribution network. Each requester presents 18-bit packets `{FIFO_content[13:0], PE_node[3:0]}`. The arbiter grants one packet per cycle into a registered output stage. Filter-row sequences are kept contiguous by locking the grant to one requester until the last row of its filter has gone out.

## Interface
Parameters:
- N_REQ, 4: number of requesting PE FIFOs (1..16).
- PKT_W, 18: packet width; fixed as 14-bit content plus 4-bit PE_node.
- FILTER_ROWS, 5: rows per filter. The row with index FILTER_ROWS-1 releases the lock.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has a packet.
- req_data  in  N_REQ×PKT_W  packet of requester i.
- req_ready  out  N_REQ  one-hot or zero; packet i is accepted this cycle.
- out_valid  out  1  output register holds a packet.
- out_data  out  PKT_W  registered packet.
- out_ready  in  1  downstream accepts out_data this cycle.
- locked  out  1  arbiter is in the LOCKED state.
- err_node  out  1  sticky flag: an accepted packet's [3:0] field was not equal to its requester index.

## Operation
- Packet fields:
  - [4]: 1 = filter, 0 = ifmap.
  - [7:5]: filter_row (filter packets only).
  - [3:0]: PE_node.
- load_en = !out_valid || out_ready. This gives a one-entry pipeline register with full throughput.
- Eligible set:
  - IDLE: all i with req_valid[i].
  - LOCKED: only lock_id, and only if req_valid[lock_id].
- Pick: round-robin starting at rr_ptr. The lowest index at or after rr_ptr, wrapping modulo N_REQ, wins.
- req_ready[g] = load_en && eligible[g] for the picked g only. Data moves when req_valid[g] && req_ready[g].
- On acceptance from g:
  - out_data <= req_data[g].
  - out_valid <= 1.
  - If req_data[g][3:0] != g, err_node <= 1.
- If out_ready fires and nothing is accepted, out_valid <= 0.
- State machine (arb_state_t):
  - IDLE → LOCKED on accepting a filter packet with row != FILTER_ROWS-1. Set lock_id <= g. rr_ptr is unchanged.
  - IDLE stays IDLE on any other acceptance. rr_ptr <= (g+1) mod N_REQ.
  - LOCKED stays LOCKED on accepting a packet from lock_id that is an ifmap packet or a filter packet with row != FILTER_ROWS-1.
  - LOCKED → IDLE on accepting a filter packet from lock_id with row == FILTER_ROWS-1. rr_ptr <= (lock_id+1) mod N_REQ.
  - In LOCKED, other requesters are never granted, even if lock_id is idle.
- N_REQ = 1: rr_ptr is constant 0. Locking still tracks state.

## Timing
- Reset values:
  - out_valid=0, out_data=0.
  - req_ready=0 while reset is asserted.
  - locked=0, err_node=0.
  - rr_ptr=0, lock_id=0, state=IDLE.
- Latency: a packet accepted in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: one packet per cycle while out_ready=1.
- req_ready is combinational from req_valid, state, rr_ptr, out_valid and out_ready. There is no combinational path from req_data.
- out_valid stays high and out_data stays stable until out_ready=1 (no retraction).
- Same-cycle drain and refill (out_valid && out_ready && acceptance): out_data is replaced, out_valid remains 1.
- Reset asserted mid-operation: all state clears immediately. Any held packet and any lock are discarded.
- err_node is cleared only by reset.

## Structure
- Package inst_arb_pkg:
  - PKT_W, PE_NODE_LSB/MSB, TYPE_BIT=4, ROW_LSB=5, ROW_MSB=7.
  - typedef enum logic {IDLE, LOCKED} arb_state_t.
  - typedef logic [PKT_W-1:0] inst_pkt_t.
- Sub-module rr_pick #(N): inputs eligible[N] and ptr. Outputs one-hot gnt[N] plus encoded index. Purely combinational.

## Test plan
- Reset, then req_valid=4'b1111 with each req_data[i][3:0]=i (ifmap packets) and out_ready=1: grants are 0,1,2,3,0 on consecutive cycles, and out_data appears one cycle later in each case.
- Lock sequence, FILTER_ROWS=5: requester 2 sends filter rows 0..4 while 0, 1 and 3 are all valid:
  - Grants go only to 2 for 5 accepts; locked=1 from after row 0 until after row 4.
  - The next grant goes to 3.
- Backpressure: out_ready=0 for 3 cycles with all requesters valid:
  - out_data is held constant and req_ready=0 throughout.
  - When out_ready returns to 1, a refill happens in the same cycle with no bubble.
- Requester 1 sends req_data[3:0]=4'h5: err_node=1 on the next cycle and stays 1 until rst_n goes low.
- Reset mid-lock (rst_n=0 after row 2): locked, out_valid and err_node all drop to 0 immediately. After release, the first grant follows rr_ptr=0.
